// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 serial transmitter: register window, byte FIFO and shift FSM.
// Read data is registered one cycle; ReadHit tells the top level to select this block.
module bus_uart_tx #(
   parameter int unsigned           WORD_WIDTH   = 16,
   parameter logic [WORD_WIDTH-1:0] BASE_ADDR    = 16'hFF00,
   parameter int unsigned           FIFO_DEPTH   = 8,
   parameter int unsigned           CLKS_PER_BIT = 16
) (
   input  logic                  gclk,
   input  logic                  PowerOn_n,
   input  logic                  MemWriteFlag,
   input  logic [WORD_WIDTH-1:0] MemWriteAddr,
   input  logic [WORD_WIDTH-1:0] MemWriteData,
   input  logic [WORD_WIDTH-1:0] MemReadAddr,
   output logic [WORD_WIDTH-1:0] MemReadData,
   output logic                  ReadHit,
   output logic                  TxD,
   output logic                  TxBusy
);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   state_e              state_q, state_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   logic [2:0]          bit_q, bit_d;
   logic [7:0]          shift_q, shift_d;
   logic                tx_q, tx_d;
   logic [7:0]          mem_q [FIFO_DEPTH];
   logic [7:0]          mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                enable_q, enable_d;
   logic                ov_q, ov_d;
   logic [WORD_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                hit_q;

   logic [WORD_WIDTH-1:0] wr_rel, rd_rel;
   logic                wr_hit, rd_hit, push_req, ctrl_wr, flush, ov_clr;
   logic                empty, full, bit_done, pop, push_ok, drop, busy_c;
   logic [3:0]          cnt_sat;
   logic [7:0]          status_c;
   logic                unused_c;

   // Window decode by offset so the compare wraps cleanly at any base
   assign wr_rel   = MemWriteAddr - BASE_ADDR;
   assign rd_rel   = MemReadAddr - BASE_ADDR;
   assign wr_hit   = MemWriteFlag && (wr_rel[WORD_WIDTH-1:2] == '0);
   assign rd_hit   = (rd_rel[WORD_WIDTH-1:2] == '0);
   assign push_req = wr_hit && (wr_rel[1:0] == 2'd0);
   assign ctrl_wr  = wr_hit && (wr_rel[1:0] == 2'd2);
   assign flush    = ctrl_wr && MemWriteData[1];
   assign ov_clr   = ctrl_wr && MemWriteData[2];
   assign unused_c = ^MemWriteData[WORD_WIDTH-1:8];

   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_W'(FIFO_DEPTH));
   assign bit_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
   // A waiting byte is taken from IDLE, or straight out of the last stop cycle
   assign pop      = enable_q && !empty &&
                     ((state_q == IDLE) || ((state_q == STOP) && bit_done));
   assign push_ok  = push_req && !flush && (!full || pop);
   assign drop     = push_req && full && !pop;
   assign busy_c   = (state_q != IDLE) || !empty;
   assign cnt_sat  = (32'(count_q) > 32'd15) ? 4'hF : 4'(count_q);
   assign status_c = {cnt_sat, ov_q, busy_c, full, empty};

   // FIFO and control register next state
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
      enable_d = ctrl_wr ? MemWriteData[0] : enable_q;
      ov_d     = (ov_q && !ov_clr) || drop;
      if (push_ok) begin
         mem_d[wr_ptr_q] = MemWriteData[7:0];
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_comb begin
      rd_data_d = '0;
      if (rd_hit) begin
         case (rd_rel[1:0])
            2'd1:    rd_data_d = WORD_WIDTH'(status_c);
            2'd2:    rd_data_d = WORD_WIDTH'(enable_q);
            default: rd_data_d = '0;
         endcase
      end
   end

   always_ff @(posedge gclk or negedge PowerOn_n) begin
      if (!PowerOn_n) state_q <= IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pop) state_d = START;
         START:   if (bit_done) state_d = DATA;
         DATA:    if (bit_done && (bit_q == 3'd7)) state_d = STOP;
         STOP:    if (bit_done) state_d = pop ? START : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Line level follows the state one cycle later; baud counter restarts per bit
   always_comb begin
      baud_d  = baud_q + BAUD_W'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = 1'b1;
      case (state_q)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_q[0];
         default: tx_d = 1'b1;
      endcase
      if ((state_q == IDLE) || bit_done) baud_d = '0;
      if ((state_q == DATA) && bit_done) begin
         shift_d = shift_q >> 1;
         bit_d   = bit_q + 3'd1;
      end
      if (pop) begin
         shift_d = mem_q[rd_ptr_q];
         bit_d   = '0;
      end
   end

   always_ff @(posedge gclk or negedge PowerOn_n) begin
      if (!PowerOn_n) begin
         baud_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         enable_q  <= 1'b0;
         ov_q      <= 1'b0;
         rd_data_q <= '0;
         hit_q     <= 1'b0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         enable_q  <= enable_d;
         ov_q      <= ov_d;
         rd_data_q <= rd_data_d;
         hit_q     <= rd_hit;
         mem_q     <= mem_d;
      end
   end

   assign MemReadData = rd_data_q;
   assign ReadHit     = hit_q;
   assign TxD         = tx_q;
   assign TxBusy      = busy_c;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Directed bench for bus_uart_tx: register vector table plus serial-frame sequences.
module tb_bus_uart_tx;
   localparam logic [15:0] A_TX   = 16'hFF00;
   localparam logic [15:0] A_ST   = 16'hFF01;
   localparam logic [15:0] A_CTRL = 16'hFF02;

   logic        gclk = 1'b0;
   logic        PowerOn_n = 1'b0;
   logic        MemWriteFlag = 1'b0;
   logic [15:0] MemWriteAddr = '0;
   logic [15:0] MemWriteData = '0;
   logic [15:0] MemReadAddr = A_ST;
   logic [15:0] MemReadData;
   logic        ReadHit, TxD, TxBusy;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        we;
      logic [15:0] wa;
      logic [15:0] wd;
      logic [15:0] ra;
      logic        exp_hit;
      logic [15:0] exp_rd;
   } vec_t;

   vec_t vecs[18];

   always #5 gclk = ~gclk;

   bus_uart_tx dut (
      .gclk(gclk), .PowerOn_n(PowerOn_n),
      .MemWriteFlag(MemWriteFlag), .MemWriteAddr(MemWriteAddr), .MemWriteData(MemWriteData),
      .MemReadAddr(MemReadAddr), .MemReadData(MemReadData), .ReadHit(ReadHit),
      .TxD(TxD), .TxBusy(TxBusy)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge gclk);
         @(negedge gclk);
      end
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
      MemWriteFlag = 1'b1;
      MemWriteAddr = a;
      MemWriteData = d;
      tick(1);
      MemWriteFlag = 1'b0;
   endtask

   task automatic read_reg(input logic [15:0] a, output logic [15:0] d);
      MemReadAddr = a;
      tick(1);
      d = MemReadData;
      MemReadAddr = A_ST;
   endtask

   task automatic wait_fall(input int bound, output int t);
      t = 0;
      while (TxD !== 1'b0 && t < bound) begin
         tick(1);
         t++;
      end
   endtask

   task automatic wait_idle(input string name, input int bound);
      int t = 0;
      while (TxBusy !== 1'b0 && t < bound) begin
         tick(1);
         t++;
      end
      check(name, 16'(TxBusy), 16'h0);
   endtask

   // Entered on the cycle TxD first reads low; leaves at the middle of the stop bit
   task automatic check_frame(input string name, input logic [7:0] b,
                              input logic [3:0] exp_cnt, input int flush_bit);
      tick(8);
      check({name, "_start"}, 16'(TxD), 16'h0);
      check({name, "_cnt"}, 16'(MemReadData[7:4]), 16'(exp_cnt));
      for (int i = 0; i < 8; i++) begin
         if (i == flush_bit) begin
            tick(15);
            bus_write(A_CTRL, 16'h0003);
         end else begin
            tick(16);
         end
         check($sformatf("%s_bit%0d", name, i), 16'(TxD), 16'(b[i]));
      end
      tick(16);
      check({name, "_stop"}, 16'(TxD), 16'h1);
   endtask

   initial begin
      logic [15:0] rd;
      int          t;
      int          lows;

      vecs[0]  = '{1'b0, 16'h0000, 16'h0000, 16'hFF01, 1'b1, 16'h0001};
      vecs[1]  = '{1'b1, 16'hFF00, 16'h0011, 16'hFF01, 1'b1, 16'h0001};
      vecs[2]  = '{1'b1, 16'hFF00, 16'h0022, 16'hFF01, 1'b1, 16'h0014};
      vecs[3]  = '{1'b0, 16'h0000, 16'h0000, 16'hFF01, 1'b1, 16'h0024};
      vecs[4]  = '{1'b0, 16'h0000, 16'h0000, 16'h0010, 1'b0, 16'h0000};
      vecs[5]  = '{1'b0, 16'h0000, 16'h0000, 16'hFF00, 1'b1, 16'h0000};
      vecs[6]  = '{1'b0, 16'h0000, 16'h0000, 16'hFF03, 1'b1, 16'h0000};
      vecs[7]  = '{1'b0, 16'h0000, 16'h0000, 16'hFF04, 1'b0, 16'h0000};
      vecs[8]  = '{1'b0, 16'h0000, 16'h0000, 16'hFEFF, 1'b0, 16'h0000};
      vecs[9]  = '{1'b1, 16'hFF03, 16'hFFFF, 16'hFF02, 1'b1, 16'h0000};
      vecs[10] = '{1'b1, 16'hFF04, 16'h0001, 16'hFF02, 1'b1, 16'h0000};
      vecs[11] = '{1'b1, 16'hFEFF, 16'h0001, 16'hFF02, 1'b1, 16'h0000};
      vecs[12] = '{1'b0, 16'h0000, 16'h0000, 16'hFF02, 1'b1, 16'h0000};
      vecs[13] = '{1'b0, 16'h0000, 16'h0000, 16'hFF01, 1'b1, 16'h0024};
      vecs[14] = '{1'b1, 16'hFF02, 16'h0002, 16'hFF01, 1'b1, 16'h0024};
      vecs[15] = '{1'b0, 16'h0000, 16'h0000, 16'hFF01, 1'b1, 16'h0001};
      vecs[16] = '{1'b1, 16'hFF02, 16'h0004, 16'hFF02, 1'b1, 16'h0000};
      vecs[17] = '{1'b0, 16'h0000, 16'h0000, 16'hFF02, 1'b1, 16'h0000};

      // Reset state
      @(negedge gclk);
      @(negedge gclk);
      check("rst_txd", 16'(TxD), 16'h1);
      check("rst_busy", 16'(TxBusy), 16'h0);
      check("rst_hit", 16'(ReadHit), 16'h0);
      check("rst_rdata", MemReadData, 16'h0000);
      PowerOn_n = 1'b1;

      // Register window and read path, transmitter disabled
      for (int i = 0; i < 18; i++) begin
         MemWriteFlag = vecs[i].we;
         MemWriteAddr = vecs[i].wa;
         MemWriteData = vecs[i].wd;
         MemReadAddr  = vecs[i].ra;
         tick(1);
         MemWriteFlag = 1'b0;
         check($sformatf("vec%0d_hit", i), 16'(ReadHit), 16'(vecs[i].exp_hit));
         check($sformatf("vec%0d_rdata", i), MemReadData, vecs[i].exp_rd);
      end
      MemReadAddr = A_ST;

      // Overflow, clear, then push and pop together while full
      for (int i = 0; i < 9; i++) bus_write(A_TX, 16'(8'h30 + i));
      read_reg(A_ST, rd);
      check("ovf_status", rd, 16'h008E);
      bus_write(A_CTRL, 16'h0004);
      read_reg(A_ST, rd);
      check("ovf_cleared", rd, 16'h0086);
      bus_write(A_CTRL, 16'h0001);
      bus_write(A_TX, 16'h0077);
      read_reg(A_ST, rd);
      check("full_push_pop", rd, 16'h0086);
      bus_write(A_CTRL, 16'h0003);
      read_reg(A_ST, rd);
      check("flush_keeps_frame", rd, 16'h0005);
      wait_idle("full_drain_idle", 400);
      tick(3);

      // Single byte with exact latency and busy timing
      bus_write(A_TX, 16'h00A5);
      wait_fall(10, t);
      check("a5_fall_delay", 16'(t), 16'd2);
      check_frame("a5", 8'hA5, 4'd0, -1);
      tick(6);
      check("a5_busy_last", 16'(TxBusy), 16'h1);
      tick(1);
      check("a5_busy_drop", 16'(TxBusy), 16'h0);
      tick(3);

      // Back-to-back frames with no idle gap
      bus_write(A_TX, 16'h0055);
      bus_write(A_TX, 16'h000F);
      wait_fall(10, t);
      check("b2b_fall_delay", 16'(t), 16'd1);
      check_frame("b2b0", 8'h55, 4'd1, -1);
      tick(7);
      check("b2b_stop_end", 16'(TxD), 16'h1);
      tick(1);
      check("b2b_no_gap", 16'(TxD), 16'h0);
      check_frame("b2b1", 8'h0F, 4'd0, -1);
      wait_idle("b2b_idle", 40);

      // Flush during the first data bits of a three-byte queue
      bus_write(A_CTRL, 16'h0000);
      bus_write(A_TX, 16'h00AA);
      bus_write(A_TX, 16'h00BB);
      bus_write(A_TX, 16'h00CC);
      bus_write(A_CTRL, 16'h0001);
      wait_fall(10, t);
      check("fl_fall_delay", 16'(t), 16'd2);
      check_frame("fl", 8'hAA, 4'd2, 1);
      wait_idle("fl_idle", 40);
      lows = 0;
      for (int i = 0; i < 400; i++) begin
         tick(1);
         if (TxD !== 1'b1) lows++;
      end
      check("fl_no_more_frames", 16'(lows), 16'h0);
      read_reg(A_ST, rd);
      check("fl_status", rd, 16'h0001);
      read_reg(A_CTRL, rd);
      check("fl_ctrl", rd, 16'h0001);

      // Asynchronous reset in the middle of a start bit
      bus_write(A_TX, 16'h0000);
      wait_fall(10, t);
      tick(3);
      check("mid_pre_txd", 16'(TxD), 16'h0);
      check("mid_pre_hit", 16'(ReadHit), 16'h1);
      #2 PowerOn_n = 1'b0;
      #1;
      check("mid_rst_txd", 16'(TxD), 16'h1);
      check("mid_rst_busy", 16'(TxBusy), 16'h0);
      check("mid_rst_hit", 16'(ReadHit), 16'h0);
      check("mid_rst_rdata", MemReadData, 16'h0000);
      @(negedge gclk);
      PowerOn_n = 1'b1;
      read_reg(A_ST, rd);
      check("post_rst_status", rd, 16'h0001);
      read_reg(A_CTRL, rd);
      check("post_rst_ctrl", rd, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
